// File: rtl/uart_tx_mmio_if.sv
// Store/load bus between the processor's memory stage and the UART transmitter.
// The master drives the store strobe, addresses and data; the slave returns load data.
interface uart_tx_mmio_if;
  logic        write_mem;
  logic [31:0] write_address;
  logic [31:0] write_data;
  logic [2:0]  funct3;
  logic [31:0] read_address;
  logic [31:0] read_data;

  modport master (
    output write_mem,
    output write_address,
    output write_data,
    output funct3,
    output read_address,
    input  read_data
  );

  modport slave (
    input  write_mem,
    input  write_address,
    input  write_data,
    input  funct3,
    input  read_address,
    output read_data
  );
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: byte stores to BASE_ADDR fill a small FIFO,
// a serializer drains it onto tx, and loads from BASE_ADDR+4 return STATUS.
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit (8E1);
// without it, frames are 8N1.
module uart_tx_mmio #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_2000,
  parameter int          CLKS_PER_BIT = 104,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_tx_mmio_if.slave  bus,
  output logic           tx
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  localparam logic [31:0]       STATUS_ADDR = BASE_ADDR + 32'd4;
  localparam logic [BAUD_W-1:0] BAUD_LAST   = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  DEPTH_CNT   = CNT_W'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  // FIFO storage and bookkeeping
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             overflow_reg;

  // Serializer state
  state_t            state_reg, state_next;
  logic [BAUD_W-1:0] baud_reg, baud_next;
  logic [2:0]        bit_reg, bit_next;
  logic [7:0]        shift_reg, shift_next;
  logic              tx_next;
`ifdef UART_TX_PARITY_EN
  logic              parity_reg, parity_next;
`endif

  logic [31:0] read_data_reg;
  logic [31:0] status_word;

  logic full, empty, push_req, clear_req, pop, push, drop, baud_done;
  logic [7:0] head;

  // Only the low byte of a store matters and the store width is irrelevant.
  logic unused_bits;
  assign unused_bits = ^{bus.funct3, bus.write_data[31:8]};

  assign full      = (count_reg == DEPTH_CNT);
  assign empty     = (count_reg == '0);
  assign push_req  = bus.write_mem && (bus.write_address == BASE_ADDR);
  assign clear_req = bus.write_mem && (bus.write_address == STATUS_ADDR);
  assign pop       = (state_reg == IDLE) && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push      = push_req && (!full || pop);
  assign drop      = push_req && full && !pop;
  assign head      = fifo_mem[rd_ptr_reg];
  assign baud_done = (baud_reg == BAUD_LAST);

  assign bus.read_data = read_data_reg;

  // FIFO payload write; storage is not reset, only the pointers are.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= bus.write_data[7:0];
    end
  end

  // FIFO pointers, occupancy count and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      if (push && !pop) begin
        count_reg <= count_reg + CNT_W'(1);
      end else if (pop && !push) begin
        count_reg <= count_reg - CNT_W'(1);
      end
      if (drop) begin
        overflow_reg <= 1'b1;
      end else if (clear_req) begin
        overflow_reg <= 1'b0;
      end
    end
  end

  // Frame sequencing: next state, counters, shifter and the next tx level.
  // tx follows the current state, so the pin lags the state by one cycle.
  always_comb begin
    state_next = state_reg;
    baud_next  = baud_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    tx_next    = 1'b1;
`ifdef UART_TX_PARITY_EN
    parity_next = parity_reg;
`endif
    case (state_reg)
      IDLE: begin
        tx_next = 1'b1;
        if (!empty) begin
          shift_next = head;
          bit_next   = '0;
          baud_next  = '0;
          state_next = START;
`ifdef UART_TX_PARITY_EN
          parity_next = ^head;
`endif
        end
      end
      START: begin
        tx_next = 1'b0;
        if (baud_done) begin
          baud_next  = '0;
          state_next = DATA;
        end else begin
          baud_next = baud_reg + BAUD_W'(1);
        end
      end
      DATA: begin
        tx_next = shift_reg[0];
        if (baud_done) begin
          baud_next  = '0;
          shift_next = {1'b0, shift_reg[7:1]};
          bit_next   = bit_reg + 3'd1;
          if (bit_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end else begin
          baud_next = baud_reg + BAUD_W'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx_next = parity_reg;
        if (baud_done) begin
          baud_next  = '0;
          state_next = STOP;
        end else begin
          baud_next = baud_reg + BAUD_W'(1);
        end
      end
`endif
      STOP: begin
        tx_next = 1'b1;
        if (baud_done) begin
          baud_next  = '0;
          state_next = IDLE;
        end else begin
          baud_next = baud_reg + BAUD_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Serializer registers; reset abandons any frame in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      baud_reg  <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      tx        <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_reg <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      baud_reg  <= baud_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      tx        <= tx_next;
`ifdef UART_TX_PARITY_EN
      parity_reg <= parity_next;
`endif
    end
  end

  // STATUS layout: busy, full, empty, overflow, then the occupancy count.
  always_comb begin
    status_word             = '0;
    status_word[0]          = (state_reg != IDLE);
    status_word[1]          = full;
    status_word[2]          = empty;
    status_word[3]          = overflow_reg;
    status_word[4 +: CNT_W] = count_reg;
  end

  // Registered load path, matching the data memory's one-cycle read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_data_reg <= '0;
    end else begin
      read_data_reg <= (bus.read_address == STATUS_ADDR) ? status_word : '0;
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio: idle/reset state, single frame timing,
// FIFO fill/overflow/clear, push on a full FIFO during a pop, mid-frame reset,
// and frame length with or without UART_TX_PARITY_EN.
module tb_uart_tx_mmio;

  localparam logic [31:0] BASE = 32'h0000_2000;
  localparam logic [31:0] STAT = 32'h0000_2004;
  localparam int CPB = 104;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_LEN = FRAME_BITS * CPB;

  logic clk;
  logic rst_n;
  logic tx;

  uart_tx_mmio_if bus();

  uart_tx_mmio #(
    .BASE_ADDR   (BASE),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave),
    .tx   (tx)
  );

  int assert_count = 0;
  int fail_count   = 0;
  int cycle_count  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle_count <= cycle_count + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycle(input int target);
    while (cycle_count < target) tick();
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assert_count++;
    if (got !== exp) begin
      fail_count++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cycle_count);
    end
  endtask

  task automatic store(input logic [31:0] addr, input logic [7:0] data, input logic [2:0] width);
    bus.write_mem     = 1'b1;
    bus.write_address = addr;
    bus.write_data    = {24'hA5C3E1, data};
    bus.funct3        = width;
    tick();
    $display("store addr=0x%08h byte=0x%02h funct3=%0d at cycle %0d", addr, data, width, cycle_count);
    bus.write_mem     = 1'b0;
    bus.write_address = '0;
    bus.write_data    = '0;
    bus.funct3        = '0;
  endtask

  // s0 is the cycle index of the first sample where tx is low for the start bit.
  task automatic receive_frame(input int s0, input logic [7:0] exp, input string tag);
    logic [7:0] got;
    got = '0;
    wait_cycle(s0 + CPB / 2);
    check_eq({tag, "_start"}, 32'(tx), 32'd0);
    for (int i = 0; i < 8; i++) begin
      wait_cycle(s0 + (i + 1) * CPB + CPB / 2);
      got[i] = tx;
    end
    check_eq({tag, "_data"}, {24'd0, got}, {24'd0, exp});
`ifdef UART_TX_PARITY_EN
    wait_cycle(s0 + 9 * CPB + CPB / 2);
    check_eq({tag, "_parity"}, 32'(tx), 32'(^exp));
`endif
    wait_cycle(s0 + (FRAME_BITS - 1) * CPB + CPB / 2);
    check_eq({tag, "_stop"}, 32'(tx), 32'd1);
    $display("frame rx byte=0x%02h start_cycle=%0d", got, s0);
  endtask

  task automatic wait_start(input int budget, output bit found, output int at);
    found = 1'b0;
    at    = 0;
    for (int i = 0; i < budget && !found; i++) begin
      if (tx == 1'b0) begin
        found = 1'b1;
        at    = cycle_count;
      end else begin
        tick();
      end
    end
  endtask

  initial begin
    int  s0;
    int  at;
    int  bad;
    bit  found;

    rst_n             = 1'b0;
    bus.write_mem     = 1'b0;
    bus.write_address = '0;
    bus.write_data    = '0;
    bus.funct3        = '0;
    bus.read_address  = STAT;

    // Reset and idle
    repeat (3) tick();
    check_eq("reset_tx", 32'(tx), 32'd1);
    check_eq("reset_status", bus.read_data, 32'd0);
    rst_n = 1'b1;
    tick();
    check_eq("idle_status", bus.read_data, 32'h4);
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (tx !== 1'b1 || bus.read_data !== 32'h4) bad++;
    end
    check_eq("idle_quiet_cycles", 32'(bad), 32'd0);

    // Single byte 0x55: latency, STATUS progression, bit pattern, return to idle
    store(BASE, 8'h55, 3'd0);
    check_eq("t2_tx_e0", 32'(tx), 32'd1);
    tick();
    check_eq("t2_tx_e1", 32'(tx), 32'd1);
    check_eq("t2_status_queued", bus.read_data, 32'h10);
    tick();
    check_eq("t2_tx_e2", 32'(tx), 32'd0);
    check_eq("t2_status_busy", bus.read_data, 32'h5);
    s0 = cycle_count;
    receive_frame(s0, 8'h55, "t2");
    wait_cycle(s0 + FRAME_LEN + 2);
    check_eq("t2_tx_after", 32'(tx), 32'd1);
    check_eq("t2_status_after", bus.read_data, 32'h4);

    // Nine consecutive stores, an overflowing tenth, then clear
    s0 = cycle_count + 3;
    for (int i = 0; i < 9; i++) begin
      store(BASE, 8'(8'h41 + i), 3'(i % 3));
    end
    store(BASE, 8'h50, 3'd2);
    tick();
    check_eq("t3_status_overflow", bus.read_data, 32'h8B);
    store(STAT, 8'hFF, 3'd2);
    tick();
    check_eq("t3_status_cleared", bus.read_data, 32'h83);
    receive_frame(s0, 8'h41, "t3_f1");

    // Push 0x4A on the very edge that pops the next byte from a full FIFO
    wait_cycle(s0 + FRAME_LEN - 1);
    store(BASE, 8'h4A, 3'd0);
    tick();
    check_eq("t4_status_full_pop_push", bus.read_data, 32'h83);
    for (int k = 2; k <= 10; k++) begin
      wait_start(2 * FRAME_LEN, found, at);
      check_eq($sformatf("t3_f%0d_found", k), 32'(found), 32'd1);
      check_eq($sformatf("t3_f%0d_start_cycle", k), 32'(at), 32'(s0 + (k - 1) * (FRAME_LEN + 1)));
      receive_frame(at, 8'(8'h40 + k), $sformatf("t3_f%0d", k));
    end
    wait_start(3 * CPB, found, at);
    check_eq("t3_no_extra_frame", 32'(found), 32'd0);
    check_eq("t3_status_drained", bus.read_data, 32'h4);

    // Two 0x07 frames back to back: parity bit and frame period
    store(BASE, 8'h07, 3'd0);
    store(BASE, 8'h07, 3'd1);
    s0 = cycle_count + 1;
    receive_frame(s0, 8'h07, "t6_f1");
    wait_start(2 * FRAME_LEN, found, at);
    check_eq("t6_found", 32'(found), 32'd1);
    check_eq("t6_frame_period", 32'(at - s0), 32'(FRAME_LEN + 1));
    receive_frame(at, 8'h07, "t6_f2");
    wait_cycle(at + FRAME_LEN + 2);
    check_eq("t6_status_after", bus.read_data, 32'h4);

    // Reset in the middle of the data bits of 0xA3
    store(BASE, 8'hA3, 3'd0);
    s0 = cycle_count + 2;
    wait_cycle(s0 + 3 * CPB + 10);
    check_eq("t5_tx_before_reset", 32'(tx), 32'(1'b0));
    rst_n = 1'b0;
    #1;
    check_eq("t5_tx_in_reset", 32'(tx), 32'd1);
    check_eq("t5_status_in_reset", bus.read_data, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check_eq("t5_status_after_release", bus.read_data, 32'h4);
    bad = 0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (tx !== 1'b1) bad++;
    end
    check_eq("t5_no_residual_bits", 32'(bad), 32'd0);
    check_eq("t5_status_final", bus.read_data, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
